// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: control and LED drive bundle for led_pattern_gen.
// master (driver side): in_mode[1:0], in_pause, in_brightness[7:0] (only with LED_PATTERN_PWM_EN) -> ; <- out_led[LED_WIDTH-1:0], out_tick
// slave (led_pattern_gen): the same signals with directions reversed.
interface led_pattern_gen_if #(
  parameter int LED_WIDTH = 6
);
  logic [1:0] in_mode;
  logic in_pause;
  logic [LED_WIDTH-1:0] out_led;
  logic out_tick;
`ifdef LED_PATTERN_PWM_EN
  logic [7:0] in_brightness;
  modport master(output in_mode, in_pause, in_brightness, input out_led, out_tick);
  modport slave(input in_mode, in_pause, in_brightness, output out_led, out_tick);
`else
  modport master(output in_mode, in_pause, input out_led, out_tick);
  modport slave(input in_mode, in_pause, output out_led, out_tick);
`endif
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern generator (count up/down, walk, bounce) with pause and registered outputs.
// Ports: in_clk clock, in_rst async active-high reset, bus (led_pattern_gen_if.slave):
//   in_mode pattern select, in_pause freeze, out_led LED drive (inverted when ACTIVE_LOW), out_tick step pulse.
// Optional macro LED_PATTERN_PWM_EN adds bus.in_brightness and an 8-bit PWM dimmer on lit bits.
module led_pattern_gen #(
  parameter int LED_WIDTH = 6,
  parameter int WAIT_TIME = 5048576,
  parameter bit ACTIVE_LOW = 1
) (
  input logic in_clk,
  input logic in_rst,
  led_pattern_gen_if.slave bus
);
  localparam int CW = $clog2(WAIT_TIME);
  localparam logic [CW-1:0] LAST = CW'(WAIT_TIME - 1);
  typedef enum logic [1:0] {COUNT_UP, COUNT_DOWN, WALK, BOUNCE} mode_t;
  mode_t mode_in, mode_q;
  logic [CW-1:0] cnt;
  logic [LED_WIDTH-1:0] pat, seed, nxt, lit;
  logic dir_up, nxt_dir, chg, tick;
  assign mode_in = mode_t'(bus.in_mode);
  assign chg = mode_in != mode_q;
  // a mode change restarts the step, so a tick landing on the same edge is dropped
  assign tick = !bus.in_pause && !chg && cnt == LAST;
  assign seed = mode_in == COUNT_UP ? {LED_WIDTH{1'b0}} :
                mode_in == COUNT_DOWN ? {LED_WIDTH{1'b1}} : LED_WIDTH'(1);
  always_comb begin
    nxt = pat;
    nxt_dir = dir_up;
    case (mode_q)
      COUNT_UP: nxt = pat + LED_WIDTH'(1);
      COUNT_DOWN: nxt = pat - LED_WIDTH'(1);
      WALK: nxt = {pat[LED_WIDTH-2:0], pat[LED_WIDTH-1]};
      BOUNCE: begin
        // turn around when the lit bit already sits at the end we are heading for
        nxt_dir = dir_up ? !pat[LED_WIDTH-1] : pat[0];
        nxt = nxt_dir ? pat << 1 : pat >> 1;
      end
    endcase
  end
`ifdef LED_PATTERN_PWM_EN
  logic [7:0] pwm_cnt;
  always_ff @(posedge in_clk or posedge in_rst)
    if (in_rst) pwm_cnt <= 8'd0;
    else pwm_cnt <= pwm_cnt + 8'd1;
  assign lit = pat & {LED_WIDTH{pwm_cnt < bus.in_brightness}};
`else
  assign lit = pat;
`endif
  always_ff @(posedge in_clk or posedge in_rst)
    if (in_rst) begin
      mode_q <= COUNT_UP;
      cnt <= '0;
      pat <= '0;
      dir_up <= 1'b1;
      bus.out_tick <= 1'b0;
      bus.out_led <= {LED_WIDTH{ACTIVE_LOW}};
    end else begin
      mode_q <= mode_in;
      bus.out_tick <= tick;
      bus.out_led <= lit ^ {LED_WIDTH{ACTIVE_LOW}};
      if (chg) begin
        pat <= seed;
        cnt <= '0;
        dir_up <= 1'b1;
      end else if (!bus.in_pause) begin
        cnt <= tick ? '0 : cnt + CW'(1);
        if (tick) begin
          pat <= nxt;
          dir_up <= nxt_dir;
        end
      end
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench for led_pattern_gen (LED_WIDTH=4, WAIT_TIME=4, ACTIVE_LOW 0 and 1 side by side).
module tb_led_pattern_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_v;
  logic pend = 1'b0;
  logic [3:0] bnc [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  led_pattern_gen_if #(.LED_WIDTH(4)) bus ();
  led_pattern_gen_if #(.LED_WIDTH(4)) bus_al ();
  assign bus_al.in_mode = bus.in_mode;
  assign bus_al.in_pause = bus.in_pause;
  led_pattern_gen #(.LED_WIDTH(4), .WAIT_TIME(4), .ACTIVE_LOW(0)) dut (.in_clk(clk), .in_rst(rst), .bus(bus));
  led_pattern_gen #(.LED_WIDTH(4), .WAIT_TIME(4), .ACTIVE_LOW(1)) dut_al (.in_clk(clk), .in_rst(rst), .bus(bus_al));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  // each out_tick pops the next expected pattern; out_led carries it one cycle later
  always @(negedge clk) begin
    if (pend) begin
      chk("step_led", bus.out_led, exp_v);
      chk("step_led_al", bus_al.out_led, ~exp_v);
      pend = 1'b0;
    end
    if (bus.out_tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tick: got tick expected none at %0t", $time);
      end else begin
        exp_v = exp_q.pop_front();
        pend = 1'b1;
      end
    end
  end
  initial begin
    bus.in_mode = 2'd0;
    bus.in_pause = 1'b0;
    cyc(3);
    chk("rst_led", bus.out_led, 4'b0000);
    chk("rst_led_al", bus_al.out_led, 4'b1111);
    chk("rst_tick", {3'b0, bus.out_tick}, 4'd0);
    for (int i = 1; i <= 17; i++) exp_q.push_back(4'(i));
    rst = 1'b0;
    cyc(68);
    bus.in_mode = 2'd1;
    cyc(2);
    chk("seed_down", bus.out_led, 4'b1111);
    for (int i = 1; i <= 16; i++) exp_q.push_back(4'(15 - i));
    cyc(63);
    bus.in_mode = 2'd3;
    cyc(2);
    chk("seed_bounce", bus.out_led, 4'b0001);
    for (int i = 0; i < 7; i++) exp_q.push_back(bnc[i]);
    cyc(27);
    bus.in_mode = 2'd2;
    cyc(2);
    chk("seed_walk", bus.out_led, 4'b0001);
    cyc(1);
    bus.in_pause = 1'b1;
    cyc(10);
    chk("pause_led", bus.out_led, 4'b0001);
    chk("pause_led_al", bus_al.out_led, 4'b1110);
    chk("pause_tick", {3'b0, bus.out_tick}, 4'd0);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    bus.in_pause = 1'b0;
    cyc(2);
    chk("resume_tick", {3'b0, bus.out_tick}, 4'd1);
    cyc(12);
    cyc(2);
    bus.in_mode = 2'd0;
    cyc(2);
    chk("seed_up_mid", bus.out_led, 4'b0000);
    exp_q.push_back(4'b0001);
    cyc(2);
    chk("early_tick", {3'b0, bus.out_tick}, 4'd0);
    cyc(1);
    chk("change_tick", {3'b0, bus.out_tick}, 4'd1);
    bus.in_pause = 1'b1;
    bus.in_mode = 2'd1;
    cyc(2);
    chk("seed_in_pause", bus.out_led, 4'b1111);
    cyc(6);
    exp_q.push_back(4'b1110);
    bus.in_pause = 1'b0;
    cyc(3);
    chk("pause_chg_early", {3'b0, bus.out_tick}, 4'd0);
    cyc(1);
    chk("pause_chg_tick", {3'b0, bus.out_tick}, 4'd1);
    cyc(3);
    bus.in_mode = 2'd2;
    cyc(2);
    chk("seed_coincident", bus.out_led, 4'b0001);
    exp_q.push_back(4'b0010);
    cyc(3);
    chk("coincident_tick", {3'b0, bus.out_tick}, 4'd1);
    cyc(2);
    #2 rst = 1'b1;
    bus.in_mode = 2'd0;
    #1;
    chk("midrst_led", bus.out_led, 4'b0000);
    chk("midrst_led_al", bus_al.out_led, 4'b1111);
    chk("midrst_tick", {3'b0, bus.out_tick}, 4'd0);
    cyc(2);
    exp_q.push_back(4'b0001);
    rst = 1'b0;
    cyc(3);
    chk("postrst_early", {3'b0, bus.out_tick}, 4'd0);
    cyc(1);
    chk("postrst_tick", {3'b0, bus.out_tick}, 4'd1);
    cyc(2);
    #2 rst = 1'b1;
    bus.in_mode = 2'd3;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    chk("rst_mode_seed", bus.out_led, 4'b0001);
    exp_q.push_back(4'b0010);
    cyc(2);
    chk("rst_mode_early", {3'b0, bus.out_tick}, 4'd0);
    cyc(1);
    chk("rst_mode_tick", {3'b0, bus.out_tick}, 4'd1);
    cyc(3);
    chk("queue_empty", 4'(exp_q.size()), 4'd0);
    chk("no_pending", {3'b0, pend}, 4'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
